// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit and the data memory controller.
interface dmem_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [AWIDTH-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [DWIDTH-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DWIDTH-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-outstanding RV32 data memory: byte/half/word loads and stores with alignment and bounds checks.
// Stores and errors respond one cycle after accept, loads after RD_LATENCY cycles; response held until consumed.
module dmem_ctrl #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH_BYTES = 1048576,
    parameter int                RD_LATENCY  = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic        err_q;
    logic        load_q;
    logic        uns_q;
    logic [1:0]  alo_q;
    logic [1:0]  size_q;
    logic [31:0] rd_word;
    logic [31:0] mem [WORDS];

    logic              accept;
    logic [2:0]        nbytes;
    logic              misalign;
    logic              req_err;
    logic [AWIDTH:0]   end_addr;
    logic [AWIDTH:0]   limit;
    logic [AWIDTH-1:0] offset;
    logic [IDXW-1:0]   idx;
    logic [3:0]        strb;
    logic [31:0]       wrep;

    assign accept = bus.req_valid_i && (state == IDLE);

    always_comb begin
        nbytes = 3'd4;
        strb   = 4'hF;
        wrep   = bus.req_wdata_i[31:0];
        case (bus.req_size_i)
            2'd0: begin
                nbytes = 3'd1;
                strb   = 4'b0001 << bus.req_addr_i[1:0];
                wrep   = {4{bus.req_wdata_i[7:0]}};
            end
            2'd1: begin
                nbytes = 3'd2;
                strb   = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
                wrep   = {2{bus.req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Bounds are computed one bit wider so a request near the top of the address space cannot wrap.
    assign end_addr = {1'b0, bus.req_addr_i} + (AWIDTH+1)'(nbytes);
    assign limit    = {1'b0, BASE_ADDR} + (AWIDTH+1)'(DEPTH_BYTES);
    assign misalign = ((bus.req_size_i == 2'd1) && bus.req_addr_i[0]) ||
                      ((bus.req_size_i == 2'd2) && (bus.req_addr_i[1:0] != 2'b00));
    assign req_err  = (bus.req_size_i == 2'd3) || misalign ||
                      (bus.req_addr_i < BASE_ADDR) || (end_addr > limit);
    assign offset   = bus.req_addr_i - BASE_ADDR;
    assign idx      = IDXW'(offset >> 2);

    // Memory has no reset so stored data survives a controller reset.
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (bus.req_we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mem[idx][b*8 +: 8] <= wrep[b*8 +: 8];
                end
            end else begin
                rd_word <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            err_q  <= 1'b0;
            load_q <= 1'b0;
            uns_q  <= 1'b0;
            alo_q  <= 2'd0;
            size_q <= 2'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    err_q  <= req_err;
                    load_q <= !bus.req_we_i;
                    uns_q  <= bus.req_unsigned_i;
                    alo_q  <= bus.req_addr_i[1:0];
                    size_q <= bus.req_size_i;
                    if (req_err || bus.req_we_i || (RD_LATENCY <= 1)) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) state <= RESP;
                    else             cnt   <= cnt - 2'd1;
                end
                RESP: if (bus.rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [31:0] shifted;
    logic [31:0] ld_ext;

    always_comb begin
        shifted = rd_word >> {alo_q, 3'b000};
        case (size_q)
            2'd0:    ld_ext = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    ld_ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_ext = rd_word;
        endcase
    end

    assign bus.req_ready_o = (state == IDLE);
    assign bus.rsp_valid_o = (state == RESP);
    assign bus.rsp_err_o   = (state == RESP) && err_q;
    assign bus.rsp_rdata_o = ((state == RESP) && load_q && !err_q) ? DWIDTH'(ld_ext) : '0;
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; fixed at 32 for RV32I lanes.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0100_0000, first valid byte address.
REQ-004 SHALL have parameter DEPTH_BYTES, default 1048576, memory size in bytes, multiple of 4.
REQ-005 SHALL have parameter RD_LATENCY, default 1, legal range 1..4, read cycles from accept to response.
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid_i  input  1  request present.
REQ-009 SHALL have port req_ready_o  output  1  request can be accepted.
REQ-010 SHALL have port req_we_i  input  1  1 store, 0 load.
REQ-011 SHALL have port req_addr_i  input  AWIDTH  byte address.
REQ-012 SHALL have port req_size_i  input  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-013 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-014 SHALL have port req_wdata_i  input  DWIDTH  store data, right-aligned.
REQ-015 SHALL have port rsp_valid_o  output  1  response present.
REQ-016 SHALL have port rsp_ready_i  input  1  response consumed.
REQ-017 SHALL have port rsp_rdata_o  output  DWIDTH  extended load data; 0 for stores and errors.
REQ-018 SHALL have port rsp_err_o  output  1  misaligned, out-of-bounds or illegal-size request.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, RESP; req_ready_o=1 only in IDLE.
REQ-020 SHALL accept a request on rising edge with req_valid_i && req_ready_o; request fields are captured at that edge.
REQ-021 SHALL flag error when size==3, half with addr[0]!=0, word with addr[1:0]!=0, addr<BASE_ADDR, or addr+bytes>BASE_ADDR+DEPTH_BYTES.
REQ-022 SHALL never modify memory for an errored request; errored request goes IDLE->RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-023 SHALL commit a valid store at the accept edge: byte strobes from size and addr[1:0], store data replicated into the addressed lane(s); unselected bytes unchanged.
REQ-024 SHALL move a store IDLE->RESP; rsp_valid_o high in the cycle after accept, rsp_err_o=0, rsp_rdata_o=0.
REQ-025 SHALL move a valid load IDLE->RESP when RD_LATENCY==1, else IDLE->WAIT with down-counter loaded RD_LATENCY-2 and WAIT->RESP when counter is 0.
REQ-026 SHALL assert rsp_valid_o for a load exactly RD_LATENCY cycles after the accept cycle.
REQ-027 SHALL extract the load byte/half by addr[1:0] and extend to 32 bits per req_unsigned_i; word loads return the full word.
REQ-028 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i=1, then return to IDLE; no new accept in that same cycle.
REQ-029 SHALL make a load accepted after a store to the same address return the stored data.
REQ-030 SHALL ignore req_valid_i, req_*_i changes while in WAIT or RESP.

Reset
REQ-031 SHALL on rst=0 force state IDLE, counter 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1 after release.
REQ-032 SHALL not clear memory contents on reset; a store committed before reset persists.
REQ-033 SHALL drop any load in WAIT or response in RESP on mid-operation reset; no response is issued for it.

Verification
REQ-034 SHALL pass: store word 0xDEADBEEF @BASE, load word @BASE with RD_LATENCY=3 -> rsp_valid_o exactly 3 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-035 SHALL pass: word 0xAAAAAAAA @BASE+4, store byte 0x55 @BASE+4, store byte 0xFF @BASE+7 -> load word 0xFFAAAA55; load byte signed @BASE+7 -> 0xFFFFFFFF; unsigned -> 0x000000FF.
REQ-036 SHALL pass: half load @BASE+1, word store @BASE+2, size=3, load @BASE-16, store @BASE+DEPTH_BYTES+8 -> each err=1, rdata 0, memory unchanged.
REQ-037 SHALL pass: load response with rsp_ready_i held 0 for 5 cycles -> rsp fields stable, req_ready_o=0 throughout; completes when rsp_ready_i=1.
REQ-038 SHALL pass: reset asserted while in WAIT -> no rsp_valid_o, IDLE after release; prior store still readable.
